// File: rtl/kamacore_pkg.sv
// Shared kamacore definitions: datapath widths, hazard FSM states and a
// saturating increment for the performance counters.
package kamacore_pkg;

    localparam int cpu_width         = 32;
    localparam int reg_addr_width    = 4;
    localparam int HAZARD_PERF_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hazard_state_t;

    function automatic logic [HAZARD_PERF_WIDTH-1:0] perf_sat_inc(
        input logic [HAZARD_PERF_WIDTH-1:0] value,
        input logic                         enable
    );
        logic [HAZARD_PERF_WIDTH-1:0] result;
        if (enable && (value != {HAZARD_PERF_WIDTH{1'b1}})) begin
            result = value + {{(HAZARD_PERF_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/kamacore_hazard_watchdog.sv
// Memory-wait watchdog: counts consecutive stall cycles and raises a sticky
// flag once the run length reaches MEM_TIMEOUT.
module kamacore_hazard_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_stall,
    output logic mem_timeout
);

    // The flag sets on the edge that brings the run length up to MEM_TIMEOUT.
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [15:0] wd_cnt_d;
    logic [15:0] wd_cnt_q;
    logic        timeout_d;
    logic        timeout_q;

    // Next run length and sticky flag
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (mem_stall) begin
            if (wd_cnt_q != 16'hFFFF) begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end else begin
                wd_cnt_d = wd_cnt_q;
            end
            if (wd_cnt_q == TIMEOUT_LAST) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            wd_cnt_d  = 16'd0;
            timeout_d = timeout_q;
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

endmodule

// File: rtl/kamacore_hazard_unit.sv
// Pipeline hazard controller: load-use stalls, memory waits and branch flushes.
// Optional performance counters are built with KAMACORE_HAZARD_PERF_EN.
module kamacore_hazard_unit
    import kamacore_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [reg_addr_width:0]   id_rs1,
    input  logic [reg_addr_width:0]   id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [reg_addr_width:0]   ex_destination_register,
    input  logic                      ex_control_memory_read,
    input  logic                      ex_control_write_register,
    input  logic                      branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_hold,
    output logic                      if_id_hold,
    output logic                      if_id_clear,
    output logic                      id_ex_hold,
    output logic                      id_ex_clear,
    output logic                      ex_mem_hold,
    output logic                      mem_wb_clear,
    output logic                      mem_timeout
`ifdef KAMACORE_HAZARD_PERF_EN
    ,
    output logic [HAZARD_PERF_WIDTH-1:0] stall_cycles,
    output logic [HAZARD_PERF_WIDTH-1:0] flush_cycles
`endif
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    hazard_state_t state_d;
    hazard_state_t state_q;
    hazard_state_t eff_state;
    logic [1:0]    flush_cnt_d;
    logic [1:0]    flush_cnt_q;
    logic          load_use;
    logic          mem_stall;

    assign load_use = ex_control_memory_read && ex_control_write_register &&
                      (ex_destination_register != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_destination_register)) ||
                       (id_uses_rs2 && (id_rs2 == ex_destination_register)));
    assign mem_stall = mem_req && !mem_ready;

    // A non-zero flush count is only ever held across a wait that began in FLUSH,
    // so it alone decides where MEM_WAIT resumes; the exit cycle acts as that state.
    assign eff_state = (state_q == MEM_WAIT) ?
                       ((flush_cnt_q != 2'd0) ? FLUSH : RUN) : state_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and flush counter
    always_comb begin
        state_d     = RUN;
        flush_cnt_d = flush_cnt_q;
        if (mem_stall) begin
            state_d = MEM_WAIT;
        end else if (branch_taken) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
        end else begin
            case (eff_state)
                FLUSH: begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    state_d     = (flush_cnt_q == 2'd1) ? RUN : FLUSH;
                end
                RUN:        state_d = load_use ? LOAD_STALL : RUN;
                LOAD_STALL: state_d = RUN;
                default:    state_d = RUN;
            endcase
        end
    end

    // Stage hold/clear decode, combinational so stage registers act this edge
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_clear = 1'b0;
        if (reset) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            mem_wb_clear = 1'b1;
        end else if (mem_stall) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_clear = 1'b1;
        end else if (branch_taken) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else begin
            case (eff_state)
                FLUSH: if_id_clear = 1'b1;
                RUN: begin
                    pc_hold     = load_use;
                    if_id_hold  = load_use;
                    id_ex_clear = load_use;
                end
                default: pc_hold = 1'b0;
            endcase
        end
    end

    kamacore_hazard_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .mem_stall   (mem_stall),
        .mem_timeout (mem_timeout)
    );

`ifdef KAMACORE_HAZARD_PERF_EN
    logic [HAZARD_PERF_WIDTH-1:0] stall_cycles_d;
    logic [HAZARD_PERF_WIDTH-1:0] stall_cycles_q;
    logic [HAZARD_PERF_WIDTH-1:0] flush_cycles_d;
    logic [HAZARD_PERF_WIDTH-1:0] flush_cycles_q;

    // Saturating performance counter update
    always_comb begin
        stall_cycles_d = perf_sat_inc(stall_cycles_q, pc_hold);
        flush_cycles_d = perf_sat_inc(flush_cycles_q, if_id_clear);
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_kamacore_hazard_unit.sv
// Scoreboard bench for kamacore_hazard_unit (FLUSH_CYCLES=3, MEM_TIMEOUT=4);
// also checks the counters when KAMACORE_HAZARD_PERF_EN is defined.
module tb_kamacore_hazard_unit;
    import kamacore_pkg::*;

    localparam int FC = 3;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_wr = 1'b0, branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear;
    logic       ex_mem_hold, mem_wb_clear, mem_timeout;
`ifdef KAMACORE_HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
    logic [31:0] ps_q[$];
    logic [31:0] pf_q[$];
    int unsigned m_pstall = 0, m_pflush = 0;
`endif

    kamacore_hazard_unit #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_destination_register(ex_rd),
        .ex_control_memory_read(ex_mem_read),
        .ex_control_write_register(ex_wr),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_clear(if_id_clear),
        .id_ex_hold(id_ex_hold), .id_ex_clear(id_ex_clear),
        .ex_mem_hold(ex_mem_hold), .mem_wb_clear(mem_wb_clear),
        .mem_timeout(mem_timeout)
`ifdef KAMACORE_HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: remaining flush-only cycles, load-use mask, stall run length.
    logic [7:0]  exp_q[$];
    int          m_flush_left = 0;
    bit          m_mask = 1'b0;
    int          m_run = 0;
    bit          m_flag = 1'b0;
    bit          stim_done = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    task automatic issue(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input bit mr, input bit wr, input bit bt,
                         input bit mq, input bit my);
        bit lu, ms, pc, ifh, ifc, idh, idc, exh, mwc, to;
        @(posedge clk);
        #1;
        reset = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_wr = wr; branch_taken = bt;
        mem_req = mq; mem_ready = my;
        lu = mr && wr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        ms = mq && !my;
        {pc, ifh, ifc, idh, idc, exh, mwc} = 7'b0;
        to = r ? 1'b0 : m_flag;
`ifdef KAMACORE_HAZARD_PERF_EN
        ps_q.push_back(r ? 32'd0 : 32'(m_pstall));
        pf_q.push_back(r ? 32'd0 : 32'(m_pflush));
`endif
        if (r) begin
            ifc = 1'b1; idc = 1'b1; mwc = 1'b1;
            m_flush_left = 0; m_mask = 1'b0; m_run = 0; m_flag = 1'b0;
`ifdef KAMACORE_HAZARD_PERF_EN
            m_pstall = 0; m_pflush = 0;
`endif
        end else begin
            if (ms) begin
                {pc, ifh, idh, exh, mwc} = 5'b11111;
                m_mask = 1'b0;
            end else if (bt) begin
                ifc = 1'b1; idc = 1'b1;
                m_flush_left = FC - 1;
                m_mask = 1'b0;
            end else if (m_flush_left > 0) begin
                ifc = 1'b1;
                m_flush_left--;
                m_mask = 1'b0;
            end else if (lu && !m_mask) begin
                pc = 1'b1; ifh = 1'b1; idc = 1'b1;
                m_mask = 1'b1;
            end else begin
                m_mask = 1'b0;
            end
            if (ms) begin
                m_run++;
                if (m_run == MT) m_flag = 1'b1;
            end else begin
                m_run = 0;
            end
`ifdef KAMACORE_HAZARD_PERF_EN
            m_pstall += int'(pc);
            m_pflush += int'(ifc);
`endif
        end
        exp_q.push_back({pc, ifh, ifc, idh, idc, exh, mwc, to});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop one expectation per cycle, compare mid-cycle
    initial begin
        logic [7:0] act, exp_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act = {pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear,
                       ex_mem_hold, mem_wb_clear, mem_timeout};
                total++;
                if (act !== exp_v) begin
                    bad++;
                    $display("FAIL outs cyc=%0d got=%b want=%b (pc,ifh,ifc,idh,idc,exh,mwc,to)",
                             cyc, act, exp_v);
                end
`ifdef KAMACORE_HAZARD_PERF_EN
                total += 2;
                if (stall_cycles !== ps_q[0]) begin
                    bad++;
                    $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", cyc, stall_cycles, ps_q[0]);
                end
                if (flush_cycles !== pf_q[0]) begin
                    bad++;
                    $display("FAIL flush_cycles cyc=%0d got=%0d want=%0d", cyc, flush_cycles, pf_q[0]);
                end
                void'(ps_q.pop_front());
                void'(pf_q.pop_front());
`endif
                cyc++;
            end else if (stim_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL time_limit monitor did not drain, got=%0d pending want=0", exp_q.size());
        $fatal(1, "time limit");
    end

    // Stimulus: directed scenarios, then randomized traffic with sporadic resets
    initial begin
        issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        idle(2);
        // load to x5, ID reads x5 as rs2, held two cycles: one bubble only
        issue(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        issue(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        idle(1);
        // load to x0, ID reads x0
        issue(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0);
        // three-cycle memory wait, released on ready
        for (int i = 0; i < 3; i++) issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        idle(1);
        // branch pulse: three flush cycles
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        idle(4);
        // branch with load-use in the same cycle
        issue(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, 0);
        idle(3);
        // load-use then branch next cycle
        issue(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 0);
        issue(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, 0);
        idle(3);
        // memory wait in the middle of a flush, flush resumes afterwards
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        idle(3);
        // six-cycle stall trips the watchdog, flag sticks until reset
        for (int i = 0; i < 6; i++) issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        idle(3);
        issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        idle(1);
        // reset in the middle of a flush leaves no residual flush
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 2000; i++) begin
            issue(($urandom_range(0, 119) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end
        idle(2);
        stim_done = 1'b1;
    end

endmodule

// File: doc/kamacore_hazard_unit.md
# kamacore_hazard_unit

Pipeline hazard controller for the kamacore five-stage pipeline. It drives the `hold`/`clear` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage interfaces and the PC hold. It sequences three hazard classes:

- load-use stalls;
- multi-cycle memory waits, with a watchdog;
- branch flushes.

It is the single owner of every stage `hold`/`clear`; no other block drives them.

## Interface

Parameters:

- `FLUSH_CYCLES`, default 1: number of cycles IF/ID is cleared after a taken branch; legal range 1–4.
- `MEM_TIMEOUT`, default 255: number of consecutive memory-wait cycles before `mem_timeout` sets; legal range 1–65535.

Ports (clock and reset first):

- `clk`  in  1  core clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  reg_addr_width+1  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the ID instruction reads rs1/rs2.
- `ex_destination_register`  in  reg_addr_width+1  rd of the instruction in EX.
- `ex_control_memory_read`  in  1  the EX instruction is a load.
- `ex_control_write_register`  in  1  the EX instruction writes rd.
- `branch_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `mem_req`  in  1  the MEM stage holds an active memory access.
- `mem_ready`  in  1  memory completes the access this cycle.
- `pc_hold`  out  1  freeze the PC.
- `if_id_hold`, `if_id_clear`  out  1  IF/ID stage control.
- `id_ex_hold`, `id_ex_clear`  out  1  ID/EX stage control.
- `ex_mem_hold`  out  1  EX/MEM stage control.
- `mem_wb_clear`  out  1  inject a bubble into WB.
- `mem_timeout`  out  1  sticky watchdog flag; cleared only by reset.
- `stall_cycles`, `flush_cycles`  out  32  performance counters; present only with `KAMACORE_HAZARD_PERF_EN`.

## Operation

Qualifiers:

- `load_use` = `ex_control_memory_read` & `ex_control_write_register` & (`ex_destination_register` ≠ 0) & ((`id_uses_rs1` & `id_rs1` == rd) | (`id_uses_rs2` & `id_rs2` == rd)).
- `mem_stall` = `mem_req` & ~`mem_ready`.

FSM states: RUN, LOAD_STALL, MEM_WAIT, FLUSH. Priority per cycle is `mem_stall` > `branch_taken` > `load_use`.

- `mem_stall`, from any state:
  - Asserts `pc_hold`, `if_id_hold`, `id_ex_hold`, `ex_mem_hold` and `mem_wb_clear`; all clears other than `mem_wb_clear` are 0.
  - Next state is MEM_WAIT. A pending flush count is preserved; FLUSH resumes after the wait ends.
- `branch_taken`, not in `mem_stall`:
  - Asserts `if_id_clear` and `id_ex_clear`.
  - Loads the flush counter with `FLUSH_CYCLES`−1. Next state is FLUSH if that value is ≠0, otherwise RUN.
- FLUSH:
  - Asserts `if_id_clear` only and decrements the counter; returns to RUN when the counter reaches 0.
  - A new `branch_taken` in FLUSH reloads the counter.
- `load_use`, in RUN only:
  - Asserts `pc_hold`, `if_id_hold` and `id_ex_clear` (a one-bubble insertion).
  - Next state is LOAD_STALL.
- LOAD_STALL: `load_use` is masked for one cycle, all outputs are 0, and the next state is RUN.
- MEM_WAIT: exits to the saved state (RUN or FLUSH) on the first cycle with ~`mem_stall`. Outputs in that exit cycle follow the normal priority.
- Watchdog:
  - A 16-bit counter increments on each `mem_stall` cycle and resets to 0 on any ~`mem_stall` cycle.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout` sets. The stall itself continues; the watchdog does not abort it.
- Hold and clear are never both asserted on the same stage.

## Timing

- State, flush counter, watchdog and performance counters are registered. Hold/clear outputs are combinational from the current state and current-cycle inputs; zero latency is required so the stage register acts on the same edge.
- Reset behaviour (asynchronous):
  - State becomes RUN and all counters become 0.
  - `mem_timeout` becomes 0.
  - While `reset` is high: `if_id_clear` = `id_ex_clear` = `mem_wb_clear` = 1, and all holds = 0.
- Reset asserted mid-stall or mid-flush abandons the operation immediately; there is no residual flush after reset.
- A load-use followed by a taken branch on the next cycle yields the flush only; the LOAD_STALL mask does not block `branch_taken`.

## Configuration

`KAMACORE_HAZARD_PERF_EN`:

- When defined:
  - `stall_cycles` increments on every cycle with `pc_hold`.
  - `flush_cycles` increments on every cycle with `if_id_clear` while not in reset.
  - Both counters are 32-bit, saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure

- Shared package `kamacore_pkg`, next to `cpu_width` and `reg_addr_width`:
  - `hazard_state_t` enum {RUN, LOAD_STALL, MEM_WAIT, FLUSH};
  - constant `HAZARD_PERF_WIDTH` = 32.
- One sub-module: `kamacore_hazard_watchdog` (counter, compare, sticky flag).
- The FSM and the output decode stay in the top module.

## Test plan

- Load to x5 in EX, ID reads x5 as rs2 → exactly one cycle of `pc_hold` = `if_id_hold` = `id_ex_clear` = 1, then all 0.
- Load to x0 in EX, ID reads x0 → no stall, all outputs 0.
- `mem_req`=1 with `mem_ready` low for 3 cycles → holds on all stages plus `mem_wb_clear` for 3 cycles, released on the `mem_ready` cycle.
- `FLUSH_CYCLES`=3, `branch_taken` pulse → `if_id_clear` for 3 cycles, `id_ex_clear` in the first cycle only.
- `branch_taken` and `load_use` in the same cycle → flush only, no `pc_hold`.
- `MEM_TIMEOUT`=4, 6-cycle memory stall → `mem_timeout` rises after the 4th stall cycle and stays 1 until `reset`.
